// File: rtl/exc_return_ctrl.sv
// Return-from-exception controller: nested saved-PC stack,
// pipeline drain sequencing and PC redirect on rfe.
module exc_return_ctrl #(
  parameter int DEPTH        = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iar_in,
  input  logic        iar_valid,
  input  logic        rfe,
  input  logic        stall,
  output logic [31:0] pc_out,
  output logic        pc_sel,
  output logic        flush,
  output logic        int_en,
  output logic [2:0]  depth,
  output logic        rfe_err,
  output logic        ovf_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DRAIN    = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;

  localparam logic [2:0] DMAX  = 3'(DEPTH);
  localparam logic [2:0] DLOAD = 3'(DRAIN_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  depth_q, depth_d;
  logic [31:0] stack_q [DEPTH];
  logic [31:0] stack_d [DEPTH];
  logic        int_en_q, int_en_d;
  logic        rfe_err_q, rfe_err_d;
  logic        ovf_err_q, ovf_err_d;
  logic [31:0] top;

  // Top-of-stack read; empty stack reads as zero.
  always_comb begin
    top = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      if (3'(i + 1) == depth_q) top = stack_q[i];
    end
  end

  assign pc_out  = top;
  assign flush   = (state_q == DRAIN) || (state_q == REDIRECT);
  assign pc_sel  = (state_q == REDIRECT) && !iar_valid && !reset;
  assign int_en  = int_en_q;
  assign depth   = depth_q;
  assign rfe_err = rfe_err_q;
  assign ovf_err = ovf_err_q;

  // Next-state: a new exception always wins over a pending return.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    depth_d   = depth_q;
    stack_d   = stack_q;
    int_en_d  = int_en_q;
    rfe_err_d = rfe_err_q;
    ovf_err_d = ovf_err_q;
    if (iar_valid) begin
      state_d  = IDLE;
      cnt_d    = 3'd0;
      int_en_d = 1'b0;
      if (depth_q < DMAX) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (3'(i) == depth_q) stack_d[i] = iar_in;
        end
        depth_d = depth_q + 3'd1;
      end else begin
        ovf_err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rfe) begin
            if (depth_q != 3'd0) begin
              state_d = DRAIN;
              cnt_d   = DLOAD;
            end else begin
              rfe_err_d = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!stall) begin
            if (cnt_q == 3'd0) state_d = REDIRECT;
            else cnt_d = cnt_q - 3'd1;
          end
        end
        REDIRECT: begin
          state_d = IDLE;
          if (depth_q != 3'd0) begin
            depth_d = depth_q - 3'd1;
            if (depth_q == 3'd1) int_en_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      depth_q   <= 3'd0;
      int_en_q  <= 1'b1;
      rfe_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      depth_q   <= depth_d;
      int_en_q  <= int_en_d;
      rfe_err_q <= rfe_err_d;
      ovf_err_q <= ovf_err_d;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

endmodule

// File: tb/tb_exc_return_ctrl.sv
// Bench for exc_return_ctrl: directed scenarios then random
// traffic, every cycle compared against a queue-based model.
module tb_exc_return_ctrl;

  localparam int DEPTH = 4;
  localparam int DRAIN_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset, iar_valid, rfe, stall;
  logic [31:0] iar_in;
  logic [31:0] pc_out;
  logic        pc_sel, flush, int_en, rfe_err, ovf_err;
  logic [2:0]  depth;

  int total = 0;
  int passed = 0;

  exc_return_ctrl #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .reset(reset), .iar_in(iar_in),
    .iar_valid(iar_valid), .rfe(rfe), .stall(stall),
    .pc_out(pc_out), .pc_sel(pc_sel), .flush(flush),
    .int_en(int_en), .depth(depth), .rfe_err(rfe_err),
    .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  // Model: saved PCs as a queue, a pending-return flag with the
  // number of unstalled flush cycles still owed, a redirect flag.
  logic [31:0] q[$];
  bit m_pend, m_redir, m_ie, m_rerr, m_oerr;
  int m_left;

  task automatic m_reset();
    q.delete();
    m_pend = 0; m_redir = 0; m_left = 0;
    m_ie = 1; m_rerr = 0; m_oerr = 0;
  endtask

  task automatic m_edge();
    if (reset) m_reset();
    else if (iar_valid) begin
      if (q.size() < DEPTH) q.push_back(iar_in);
      else m_oerr = 1;
      m_ie = 0; m_pend = 0; m_redir = 0;
    end else if (m_redir) begin
      if (q.size() > 0) void'(q.pop_back());
      if (q.size() == 0) m_ie = 1;
      m_redir = 0;
    end else if (m_pend) begin
      if (!stall) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_pend = 0; m_redir = 1;
        end
      end
    end else if (rfe) begin
      if (q.size() > 0) begin
        m_pend = 1; m_left = DRAIN_CYCLES;
      end else m_rerr = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_all();
    logic [31:0] e_pc;
    e_pc = (q.size() > 0) ? q[q.size()-1] : 32'h0;
    chk("flush", 32'(flush), 32'(m_pend || m_redir));
    chk("pc_sel", 32'(pc_sel), 32'(m_redir && !iar_valid && !reset));
    chk("pc_out", pc_out, e_pc);
    chk("depth", 32'(depth), 32'(q.size()));
    chk("int_en", 32'(int_en), 32'(m_ie));
    chk("rfe_err", 32'(rfe_err), 32'(m_rerr));
    chk("ovf_err", 32'(ovf_err), 32'(m_oerr));
  endtask

  task automatic cyc(input bit iv, input logic [31:0] d,
                     input bit r, input bit s, input bit rs);
    iar_valid = iv; iar_in = d; rfe = r; stall = s; reset = rs;
    @(negedge clk);
    check_all();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; iar_valid = 0; rfe = 0; stall = 0; iar_in = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 1);
    idle(1);
    // single return
    cyc(1, 32'h0001_0040, 0, 0, 0);
    idle(3);
    cyc(0, 0, 1, 0, 0);
    idle(5);
    chk("single_int_en", 32'(int_en), 32'h1);
    // nesting
    cyc(1, 32'h0001_0100, 0, 0, 0);
    cyc(1, 32'h0001_0200, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle(4);
    chk("nest_pc", pc_out, 32'h0001_0100);
    chk("nest_int_en0", 32'(int_en), 32'h0);
    cyc(0, 0, 1, 0, 0);
    idle(4);
    chk("nest_int_en1", 32'(int_en), 32'h1);
    // stall during drain
    cyc(1, 32'h0001_0300, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    idle(5);
    // abort by new exception in first drain cycle
    cyc(1, 32'h0001_0400, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 32'h0001_0008, 0, 0, 0);
    idle(2);
    chk("abort_top", pc_out, 32'h0001_0008);
    chk("abort_depth", 32'(depth), 32'd2);
    // rfe and push same cycle
    cyc(1, 32'h0001_0500, 1, 0, 0);
    idle(2);
    // errors
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    idle(1);
    chk("rfe_err", 32'(rfe_err), 32'h1);
    for (int i = 1; i <= 5; i++) cyc(1, 32'h0002_0000 + i, 0, 0, 0);
    idle(1);
    chk("ovf_depth", 32'(depth), 32'd4);
    chk("ovf_top", pc_out, 32'h0002_0004);
    // reset mid-drain
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    idle(4);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(7) == 0), $urandom(),
          ($urandom_range(3) == 0), ($urandom_range(2) == 0),
          ($urandom_range(99) == 0));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/exc_return_ctrl.md
EXC_RETURN_CTRL -- requirements
Module: exc_return_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of nested saved-PC entries.
REQ-002 The block SHALL have parameter DRAIN_CYCLES, default 2, meaning the number of flush cycles before a return redirect (legal range 1-7).
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-005 The block SHALL have port iar_in, input, width 32: the saved PC presented by the interrupt address register.
REQ-006 The block SHALL have port iar_valid, input, width 1: a one-cycle strobe marking an exception taken, with iar_in valid that cycle.
REQ-007 The block SHALL have port rfe, input, width 1: a one-cycle strobe marking a decoded return-from-exception.
REQ-008 The block SHALL have port stall, input, width 1: a pipeline stall that freezes the drain counter.
REQ-009 The block SHALL have port pc_out, output, width 32: the return target.
REQ-010 The block SHALL have port pc_sel, output, width 1: a one-cycle strobe telling the PC mux to load pc_out.
REQ-011 The block SHALL have port flush, output, width 1: squashes younger pipeline stages.
REQ-012 The block SHALL have port int_en, output, width 1: interrupt enable.
REQ-013 The block SHALL have port depth, output, width 3: the current stack occupancy, 0..DEPTH.
REQ-014 The block SHALL have port rfe_err, output, width 1: sticky flag for rfe on an empty stack.
REQ-015 The block SHALL have port ovf_err, output, width 1: sticky flag for a push on a full stack.

Function
REQ-016 Stack: iar_valid SHALL push iar_in onto a LIFO; pop SHALL return the most recent entry.
REQ-017 The push SHALL take effect at the edge where iar_valid is sampled; depth SHALL increment the same edge and int_en SHALL clear.
REQ-018 Push when depth==DEPTH:
  - iar_in is discarded.
  - Contents are unchanged.
  - ovf_err is set.
REQ-019 The FSM SHALL have states IDLE, DRAIN and REDIRECT.
REQ-020 IDLE, rfe=1, depth>0, iar_valid=0: the FSM SHALL move to DRAIN and load the counter with DRAIN_CYCLES-1.
REQ-021 IDLE, rfe=1, depth==0: the FSM SHALL stay in IDLE, set rfe_err, and assert no flush or pc_sel.
REQ-022 DRAIN: flush=1 every cycle; the counter decrements when stall=0 and holds when stall=1; at counter==0 with stall=0 the FSM SHALL move to REDIRECT.
REQ-023 Flush SHALL therefore be high for exactly DRAIN_CYCLES unstalled cycles, beginning the cycle after the rfe edge.
REQ-024 REDIRECT (exactly one cycle, regardless of stall):
  - pc_sel=1, flush=1, pc_out=top entry.
  - The pop happens at the closing edge; depth decrements.
  - If the new depth==0, int_en SHALL set at that edge.
  - Next state is IDLE.
REQ-025 pc_out SHALL equal the top entry whenever depth>0, and 32'h0000_0000 when the stack is empty; the value is combinational from the stack.
REQ-026 iar_valid in DRAIN or REDIRECT:
  - The pending return is aborted.
  - The push occurs; no pop occurs.
  - pc_sel stays low.
  - The FSM returns to IDLE at the same edge.
REQ-027 rfe and iar_valid in the same IDLE cycle: the push SHALL win and the rfe SHALL be ignored.
REQ-028 rfe while not in IDLE SHALL be ignored.
REQ-029 The stack SHALL not wrap: depth saturates at DEPTH and at 0.
REQ-030 rfe_err and ovf_err SHALL clear only on reset.

Reset
REQ-031 reset=1 at a rising edge SHALL produce:
  - state=IDLE, counter=0, depth=0, all entries=0.
  - int_en=1, flush=0, pc_sel=0, pc_out=0, rfe_err=0, ovf_err=0.
REQ-032 Reset SHALL take priority over iar_valid, rfe and stall, including mid-DRAIN or in REDIRECT; no pc_sel pulse SHALL follow.

Verification
REQ-033 Single return: push 32'h0001_0040, then rfe 3 cycles later -> flush high 2 cycles, then pc_sel=1 with pc_out=32'h0001_0040 for one cycle, depth 1->0, int_en 0->1.
REQ-034 Nesting: push 32'h0001_0100 and 32'h0001_0200, then two rfes -> redirects to 0x0001_0200 then 0x0001_0100; int_en stays 0 after the first return and goes to 1 after the second.
REQ-035 Stall: rfe with stall held high 3 cycles during DRAIN -> flush lasts 5 cycles; pc_sel comes one cycle later; the target is unchanged.
REQ-036 Abort: rfe, then iar_valid with 32'h0001_0008 in the first DRAIN cycle -> no pc_sel; depth increments; top=0x0001_0008; FSM in IDLE.
REQ-037 Errors: rfe at depth 0 -> rfe_err=1 and no flush; 5 pushes with DEPTH=4 -> ovf_err=1, depth=4, and the top is still the 4th value.
REQ-038 Reset mid-DRAIN -> the next cycle shows all outputs at their reset values and no pc_sel pulse.
